// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg: shared scan-controller types and constants.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package display_pkg;

  localparam int NUM_DIGITS       = 4;
  localparam int SEL_W            = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;
  localparam int DEF_REFRESH_DIV  = 100000;
  localparam int DEF_BLANK_CYCLES = 1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_e;

  // Active-low anode pattern for the selected digit, suppressed when masked.
  function automatic logic [NUM_DIGITS-1:0] anode_for(
    input logic [SEL_W-1:0]      sel,
    input logic [NUM_DIGITS-1:0] mask
  );
    logic [NUM_DIGITS-1:0] an;
    an = AN_OFF;
    if (!mask[sel]) an[sel] = 1'b0;
    return an;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen: free-running 0..DIV-1 prescaler with synchronous clear.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tick_gen #(
  parameter int DIV = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   CLR,
  output logic                   TICK,
  output logic [$clog2(DIV)-1:0] COUNT
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (CLR || (count_q == LAST)) count_d = '0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) count_q <= '0;
    else       count_q <= count_d;
  end

  assign TICK  = (count_q == LAST);
  assign COUNT = count_q;

endmodule

`default_nettype wire

// File: rtl/display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl: 4-digit multiplexed display scanner with blanking.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ENABLE,
  input  logic [NUM_DIGITS-1:0] BLANK_MASK,
  output logic [SEL_W-1:0]      CONTROL,
  output logic [NUM_DIGITS-1:0] AN,
  output logic                  DIGIT_TICK
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  // Last prescaler value spent in BLANK; unused when blanking is disabled.
  localparam logic [CNT_W-1:0] BLANK_LAST =
    CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  localparam scan_state_e SLOT_START = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

  if (REFRESH_DIV < 2 || BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV) begin : g_param_check
    $error("display_scan_ctrl: need REFRESH_DIV>=2 and 0<=BLANK_CYCLES<REFRESH_DIV");
  end

  scan_state_e           state_d, state_q;
  logic [SEL_W-1:0]      control_d, control_q;
  logic [NUM_DIGITS-1:0] an_d, an_q;
  logic                  digit_tick_d, digit_tick_q;

  logic                  presc_clr;
  logic                  presc_tc;
  logic [CNT_W-1:0]      presc_count;

  assign presc_clr = !ENABLE || (state_q == ST_IDLE);

  tick_gen #(
    .DIV (REFRESH_DIV)
  ) u_prescaler (
    .CLK   (CLK),
    .RESET (RESET),
    .CLR   (presc_clr),
    .TICK  (presc_tc),
    .COUNT (presc_count)
  );

  always_comb begin
    state_d      = state_q;
    control_d    = control_q;
    digit_tick_d = 1'b0;

    if (!ENABLE) begin
      // Disable wins over a coincident terminal count.
      state_d   = ST_IDLE;
      control_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = SLOT_START;
          control_d = '0;
        end
        ST_BLANK, ST_SHOW: begin
          if (presc_tc) begin
            state_d      = SLOT_START;
            control_d    = control_q + SEL_W'(1);
            digit_tick_d = 1'b1;
          end else if (state_q == ST_BLANK && presc_count == BLANK_LAST) begin
            state_d = ST_SHOW;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          control_d = '0;
        end
      endcase
    end

    an_d = (state_d == ST_SHOW) ? anode_for(control_d, BLANK_MASK) : AN_OFF;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      control_q    <= '0;
      an_q         <= AN_OFF;
      digit_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      control_q    <= control_d;
      an_q         <= an_d;
      digit_tick_q <= digit_tick_d;
    end
  end

  assign CONTROL    = control_q;
  assign AN         = an_q;
  assign DIGIT_TICK = digit_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_display_scan_ctrl: random + directed checks of two builds against a model.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_display_scan_ctrl;

  localparam int DIV = 8;
  localparam int BLK = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] mask = 4'b0000;

  logic [1:0] ctl_a, ctl_b;
  logic [3:0] an_a, an_b;
  logic       tick_a, tick_b;

  int n_checks = 0;
  int n_errors = 0;

  // Model: slot position since slot start, active digit, running flag.
  bit         m_run  = 1'b0;
  int         m_k    = 0;
  int         m_sel  = 0;
  bit         m_tick = 1'b0;
  logic [3:0] m_mask = 4'b0000;

  always #5 clk = ~clk;

  display_scan_ctrl #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLK)) u_dut (
    .CLK(clk), .RESET(rst), .ENABLE(enable), .BLANK_MASK(mask),
    .CONTROL(ctl_a), .AN(an_a), .DIGIT_TICK(tick_a)
  );

  display_scan_ctrl #(.REFRESH_DIV(DIV), .BLANK_CYCLES(0)) u_dut_noblank (
    .CLK(clk), .RESET(rst), .ENABLE(enable), .BLANK_MASK(mask),
    .CONTROL(ctl_b), .AN(an_b), .DIGIT_TICK(tick_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [3:0] model_an(input int blank);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << m_sel;
    if (m_run && m_k >= blank && !m_mask[m_sel]) return ~one_hot;
    return 4'b1111;
  endfunction

  task automatic model_edge();
    m_tick = 1'b0;
    if (rst || !enable) begin
      m_run = 1'b0; m_k = 0; m_sel = 0;
    end else if (!m_run) begin
      m_run = 1'b1; m_k = 0; m_sel = 0;
    end else begin
      m_k++;
      if (m_k == DIV) begin
        m_k = 0; m_sel = (m_sel + 1) % 4; m_tick = 1'b1;
      end
    end
    m_mask = mask;
  endtask

  task automatic compare_all();
    check_val("an_blk",      an_a,   model_an(BLK));
    check_val("an_noblk",    an_b,   model_an(0));
    check_val("ctl_blk",     ctl_a,  m_sel);
    check_val("ctl_noblk",   ctl_b,  m_sel);
    check_val("tick_blk",    tick_a, m_tick);
    check_val("tick_noblk",  tick_b, m_tick);
    check_val("onelow_blk",  ($countones(~an_a) <= 1), 1);
    check_val("onelow_noblk",($countones(~an_b) <= 1), 1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int guard;
    int ticks;

    // Asynchronous reset takes effect before any clock edge.
    #3 rst = 1'b1;
    #1;
    check_val("rst_an",   an_a,   4'hF);
    check_val("rst_ctl",  ctl_a,  0);
    check_val("rst_tick", tick_a, 0);
    check_val("rst_an0",  an_b,   4'hF);
    repeat (3) step();

    // Enable from reset; count advances over one full scan plus one.
    rst = 1'b0; enable = 1'b1; mask = 4'b0000;
    ticks = 0;
    for (int i = 0; i < 33; i++) begin
      step();
      if (tick_a) ticks++;
    end
    check_val("tick_count", ticks, 4);
    check_val("ctl_wrap",   ctl_a, 0);

    // Masked digit 2 stays dark for its whole slot.
    mask = 4'b0100;
    repeat (32) step();
    mask = 4'b0000;

    // Drop enable on the terminal count of slot 2.
    guard = 0;
    while (!(m_k == DIV - 1 && m_sel == 2) && guard < 40) begin step(); guard++; end
    check_val("find_tc_slot2", (m_k == DIV - 1 && m_sel == 2), 1);
    enable = 1'b0;
    step();
    check_val("dis_ctl",  ctl_a,  0);
    check_val("dis_an",   an_a,   4'hF);
    check_val("dis_tick", tick_a, 0);
    enable = 1'b1;
    repeat (12) step();

    // Asynchronous reset in the middle of slot 3's visible phase.
    guard = 0;
    while (!(m_sel == 3 && m_k == BLK + 2) && guard < 40) begin step(); guard++; end
    check_val("find_show3", (m_sel == 3 && m_k == BLK + 2), 1);
    check_val("show3_an", an_a, 4'b0111);
    #2 rst = 1'b1;
    #1;
    check_val("arst_an",  an_a,  4'hF);
    check_val("arst_ctl", ctl_a, 0);
    check_val("arst_an0", an_b,  4'hF);
    step();
    rst = 1'b0;
    repeat (12) step();

    // Randomized run with occasional disables, resets and mask changes.
    for (int i = 0; i < 600; i++) begin
      enable = ($urandom_range(0, 39) != 0);
      rst    = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 7) == 0) mask = 4'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, SHALL set clock cycles per digit slot (1 kHz per digit at 100 MHz).
REQ-002 Parameter BLANK_CYCLES, default 1000, SHALL set anode-off cycles at the start of each slot; legal range 0..REFRESH_DIV-1.
REQ-003 CLK  in  1  SHALL be the single system clock; all state on rising edge.
REQ-004 RESET  in  1  SHALL be asynchronous, active-high reset.
REQ-005 ENABLE  in  1  SHALL be the scan enable; low blanks the display.
REQ-006 BLANK_MASK  in  4  SHALL suppress digit n's anode when bit n is 1.
REQ-007 CONTROL  out  2  SHALL be the digit select driving the downstream 4-way 5-bit digit multiplexer.
REQ-008 AN  out  4  SHALL be the active-low anode enables; bit n pairs with CONTROL==n.
REQ-009 DIGIT_TICK  out  1  SHALL pulse one cycle on each CONTROL advance.

Function
REQ-010 All outputs SHALL be registered, with no combinational path from input to output.
REQ-011 The FSM SHALL have exactly three states: IDLE, BLANK, SHOW.
REQ-012 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0 while in BLANK or SHOW; it SHALL be held at 0 in IDLE.
REQ-013 On prescaler terminal count, the block SHALL increment CONTROL modulo 4 (3 wraps to 0), pulse DIGIT_TICK for the next cycle, and enter BLANK.
REQ-014 In BLANK, AN SHALL be 4'b1111; the FSM SHALL leave for SHOW when prescaler reaches BLANK_CYCLES.
REQ-015 With BLANK_CYCLES==0, BLANK SHALL be skipped and SHOW entered directly from the advance.
REQ-016 In SHOW, AN SHALL be ~(1<<CONTROL) masked: the bit SHALL be 1 when BLANK_MASK[CONTROL]==1; BLANK_MASK SHALL be sampled every cycle.
REQ-017 Slot period SHALL be exactly REFRESH_DIV cycles, unaffected by BLANK_CYCLES or BLANK_MASK.
REQ-018 ENABLE low in any state SHALL force IDLE on the next edge: AN=1111, CONTROL=0, prescaler=0, DIGIT_TICK=0.
REQ-019 ENABLE rising from IDLE SHALL enter BLANK with CONTROL=0 and prescaler=0, without a DIGIT_TICK pulse.
REQ-020 ENABLE falling in the same cycle as terminal count SHALL take priority: no advance and no DIGIT_TICK.
REQ-021 At any time, at most one AN bit SHALL be 0.

Reset
REQ-022 RESET asserted SHALL immediately force IDLE, CONTROL=0, AN=4'b1111, DIGIT_TICK=0, and prescaler=0, including mid-slot.
REQ-023 After RESET releases with ENABLE high, the first edge SHALL behave as REQ-019.

Structure
REQ-024 Shared package display_pkg SHALL hold the FSM state encoding, NUM_DIGITS=4, AN_OFF=4'b1111, and default REFRESH_DIV/BLANK_CYCLES.
REQ-025 Prescaler SHALL be one sub-module, tick_gen (parameter DIV; ports CLK, RESET, CLR, TICK, COUNT).
REQ-026 Parameter legality (BLANK_CYCLES<REFRESH_DIV, REFRESH_DIV>=2) SHALL be checked at elaboration.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-027 Reset then ENABLE=1, MASK=0 -> AN=1111 for 2 cycles, then 1110 for 6; at cycle 8 DIGIT_TICK=1, CONTROL=1, AN=1111 for 2, then 1101.
REQ-028 Run 32 cycles -> CONTROL sequence 0,1,2,3,0 with exactly 4 DIGIT_TICK pulses spaced 8 apart.
REQ-029 MASK=4'b0100 -> AN stays 1111 throughout CONTROL=2; other slots unaffected; period still 8.
REQ-030 ENABLE dropped at prescaler=7, CONTROL=2 -> next cycle IDLE, CONTROL=0, AN=1111, no DIGIT_TICK.
REQ-031 RESET pulsed mid-SHOW at CONTROL=3 -> AN=1111 and CONTROL=0 asynchronously; after release, restart per REQ-027.
REQ-032 BLANK_CYCLES=0 build -> AN=1110 on the first enabled cycle; every cycle thereafter shows exactly one low AN bit.
